// File: rtl/password_sender_pkg.sv
`default_nettype none
// ============================================================================
// Module      : password_sender_pkg
// Description : Shared types and constants for the password_sender slice:
//               the FSM state encoding, the admin recovery code and the
//               default idle digit value.
// Revision    : 1.0 - initial release
// ============================================================================
package password_sender_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEND  = 3'd1,
    S_WAIT  = 3'd2,
    S_ADMIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // Admin recovery sequence 0,1,2,9; digit 0 sits in the low nibble and is
  // shifted out first.
  localparam int              ADMIN_LEN          = 4;
  localparam logic [15:0]     ADMIN_CODE         = 16'h9210;
  localparam logic [3:0]      IDLE_DIGIT_DEFAULT = 4'hF;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/password_sender_serializer.sv
`default_nettype none
// ============================================================================
// Module      : digit_serializer
// Description : Loads a vector of NDIG 4-bit digits and presents them one per
//               enabled cycle on a registered digit/valid pair. Digit 0 (the
//               low nibble) appears on the cycle after load. last_o flags
//               that the digit currently on digit_o is the final one, so the
//               next shift returns the output to IDLE_DIGIT.
// Ports       : clk_i, rst_i     - clock, synchronous active-high reset
//               load_i, data_i   - load a new digit vector (priority over
//                                  shift)
//               len_i            - number of digits to send from data_i
//               shift_i          - advance to the next digit
//               digit_o, valid_o - registered digit output and qualifier
//               last_o           - current digit is the final one
// Revision    : 1.0 - initial release
// ============================================================================
module digit_serializer
  import password_sender_pkg::*;
#(
  parameter int         NDIG       = 4,
  parameter logic [3:0] IDLE_DIGIT = IDLE_DIGIT_DEFAULT,
  parameter int         IW         = $clog2(NDIG + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [NDIG*4-1:0] data_i,
  input  logic [IW-1:0]     len_i,
  input  logic              shift_i,
  output logic [3:0]        digit_o,
  output logic              valid_o,
  output logic              last_o
);

  logic [NDIG*4-1:0] sr_q;
  logic [IW-1:0]     idx_q;
  logic [IW-1:0]     len_q;
  logic [3:0]        digit_q;
  logic              valid_q;
  logic              w_last;

  assign w_last = valid_q && ((idx_q + IW'(1)) == len_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q    <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      digit_q <= IDLE_DIGIT;
      valid_q <= 1'b0;
    end else if (load_i) begin
      // Digit 0 goes straight to the output; the remainder waits in sr_q.
      digit_q <= data_i[3:0];
      sr_q    <= data_i >> 4;
      idx_q   <= '0;
      len_q   <= len_i;
      valid_q <= 1'b1;
    end else if (shift_i && valid_q) begin
      if (w_last) begin
        digit_q <= IDLE_DIGIT;
        valid_q <= 1'b0;
        idx_q   <= '0;
        sr_q    <= '0;
      end else begin
        digit_q <= sr_q[3:0];
        sr_q    <= sr_q >> 4;
        idx_q   <= idx_q + IW'(1);
      end
    end
  end

  assign digit_o = digit_q;
  assign valid_o = valid_q;
  assign last_o  = w_last;

endmodule
`default_nettype wire

// File: rtl/password_sender.sv
`default_nettype none
// ============================================================================
// Module      : password_sender
// Description : Serial transmitter for the password lock's digit bus. On a
//               start request it latches a DIGITS-digit code, sends it one
//               digit per clock, then watches the lock's result lights and
//               reports success / failure with a single-cycle done pulse.
//               Optional macro PASSWORD_SENDER_ADMIN_EN: when defined, a
//               lockdown (warningLight) plays the admin recovery sequence
//               0,1,2,9 before finishing; when undefined, lockdown is
//               reported as a plain failure with lockedOut set.
// Ports       : CLK, RST                 - clock, synchronous active-high reset
//               start, code              - attempt request and code to send
//               digit, digitValid        - digit bus to the lock
//               busy, done               - activity flag, completion pulse
//               success, lockedOut       - result of the last attempt
//               unlockLight, errorLight,
//               warningLight             - lock result indicators
// Revision    : 1.0 - initial release
// ============================================================================
module password_sender
  import password_sender_pkg::*;
#(
  parameter int         DIGITS       = 4,
  parameter logic [3:0] IDLE_DIGIT   = IDLE_DIGIT_DEFAULT,
  parameter int         RESP_TIMEOUT = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic [4*DIGITS-1:0] code,
  output logic [3:0]          digit,
  output logic                digitValid,
  output logic                busy,
  output logic                done,
  output logic                success,
  output logic                lockedOut,
  input  logic                unlockLight,
  input  logic                errorLight,
  input  logic                warningLight
);

  // The serializer is shared between the code and the admin sequence, so it
  // must be wide enough for whichever is longer.
  localparam int NDIG = max_int(DIGITS, ADMIN_LEN);
  localparam int IW   = $clog2(NDIG + 1);
  localparam int CW   = $clog2(RESP_TIMEOUT + 1);

  state_e            state_q;
  logic [CW-1:0]     wait_cnt_q;
  logic              busy_q;
  logic              done_q;
  logic              success_q;
  logic              locked_q;

  logic              w_ser_load;
  logic              w_ser_shift;
  logic              w_ser_last;
  logic [NDIG*4-1:0] w_ser_data;
  logic [IW-1:0]     w_ser_len;

  // Serializer control decoded from the current state.
  always_comb begin
    w_ser_load              = 1'b0;
    w_ser_shift             = 1'b0;
    w_ser_len               = IW'(DIGITS);
    w_ser_data              = '0;
    w_ser_data[4*DIGITS-1:0] = code;
    case (state_q)
      S_IDLE: w_ser_load = start;
      S_SEND: w_ser_shift = 1'b1;
`ifdef PASSWORD_SENDER_ADMIN_EN
      S_WAIT: begin
        if (warningLight) begin
          w_ser_load                  = 1'b1;
          w_ser_data                  = '0;
          w_ser_data[4*ADMIN_LEN-1:0] = ADMIN_CODE;
          w_ser_len                   = IW'(ADMIN_LEN);
        end
      end
      S_ADMIN: w_ser_shift = 1'b1;
`endif
      default: ;
    endcase
  end

  digit_serializer #(
    .NDIG       (NDIG),
    .IDLE_DIGIT (IDLE_DIGIT),
    .IW         (IW)
  ) u_ser (
    .clk_i   (CLK),
    .rst_i   (RST),
    .load_i  (w_ser_load),
    .data_i  (w_ser_data),
    .len_i   (w_ser_len),
    .shift_i (w_ser_shift),
    .digit_o (digit),
    .valid_o (digitValid),
    .last_o  (w_ser_last)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      success_q  <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_SEND;
            busy_q    <= 1'b1;
            success_q <= 1'b0;
            locked_q  <= 1'b0;
          end
        end

        S_SEND: begin
          if (w_ser_last) begin
            state_q    <= S_WAIT;
            wait_cnt_q <= CW'(RESP_TIMEOUT);
          end
        end

        S_WAIT: begin
          wait_cnt_q <= wait_cnt_q - CW'(1);
          if (warningLight) begin
            locked_q   <= 1'b1;
            success_q  <= 1'b0;
            wait_cnt_q <= '0;
`ifdef PASSWORD_SENDER_ADMIN_EN
            state_q    <= S_ADMIN;
`else
            state_q    <= S_DONE;
`endif
          end else if (errorLight) begin
            success_q  <= 1'b0;
            wait_cnt_q <= '0;
            state_q    <= S_DONE;
          end else if (unlockLight) begin
            success_q  <= 1'b1;
            wait_cnt_q <= '0;
            state_q    <= S_DONE;
          end else if (wait_cnt_q == CW'(1)) begin
            // This sample takes the counter to zero: timeout.
            success_q <= 1'b0;
            state_q   <= S_DONE;
          end
        end

`ifdef PASSWORD_SENDER_ADMIN_EN
        S_ADMIN: begin
          if (w_ser_last) begin
            state_q <= S_DONE;
          end
        end
`endif

        S_DONE: begin
          // First cycle raises done; the second leaves while done is seen,
          // so a held start is next sampled one cycle after the pulse.
          if (!done_q) begin
            done_q <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign success   = success_q;
  assign lockedOut = locked_q;

endmodule
`default_nettype wire

// File: tb/tb_password_sender.sv
`default_nettype none
// ============================================================================
// Module      : tb_password_sender
// Description : Self-checking bench for password_sender (DIGITS=4,
//               RESP_TIMEOUT=8). Directed per-edge stimulus tables feed both
//               the DUT and a timeline model that derives every expected
//               output from the attempt timing rules; a few hand-computed
//               literal checks pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_password_sender;

  localparam int D = 4;
  localparam int T = 8;
  localparam int N = 330;
`ifdef PASSWORD_SENDER_ADMIN_EN
  localparam bit ADM = 1'b1;
`else
  localparam bit ADM = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST, start, unlockLight, errorLight, warningLight;
  logic [15:0] code;
  logic [3:0]  digit;
  logic        digitValid, busy, done, success, lockedOut;

  password_sender dut (
    .CLK          (CLK),
    .RST          (RST),
    .start        (start),
    .code         (code),
    .digit        (digit),
    .digitValid   (digitValid),
    .busy         (busy),
    .done         (done),
    .success      (success),
    .lockedOut    (lockedOut),
    .unlockLight  (unlockLight),
    .errorLight   (errorLight),
    .warningLight (warningLight)
  );

  always #5 CLK = ~CLK;

  // Stimulus: value sampled by the DUT at edge e.
  bit          rst_at [N];
  bit          start_at [N];
  bit          unl_at [N];
  bit          err_at [N];
  bit          warn_at [N];
  logic [15:0] code_at [N];

  // Expected outputs just after edge e.
  logic [3:0]  e_digit [N];
  bit          e_valid [N];
  bit          e_busy [N];
  bit          e_done [N];
  bit          e_chk [N];
  bit          e_succ [N];
  bit          e_lock [N];
  int          ev_kind [N];   // 1 reset, 2 accept, 3 done
  bit          ev_s [N];
  bit          ev_l [N];

  // Observed outputs after edge e.
  logic [3:0]  o_digit [N];
  logic        o_valid [N];
  logic        o_busy [N];
  logic        o_done [N];
  logic        o_succ [N];
  logic        o_lock [N];

  int ntests = 0;
  int nfail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] admin_digit(input int i);
    case (i)
      0:       return 4'd0;
      1:       return 4'd1;
      2:       return 4'd2;
      default: return 4'd9;
    endcase
  endfunction

  task automatic build_stimulus();
    for (int e = 0; e < N; e++) begin
      rst_at[e] = 0; start_at[e] = 0; unl_at[e] = 0; err_at[e] = 0;
      warn_at[e] = 0; code_at[e] = 16'h0000;
    end
    for (int e = 0; e < 3; e++) rst_at[e] = 1;
    // Success: unlock on the second result sample.
    start_at[5] = 1;   code_at[5] = 16'h4321;   unl_at[11] = 1;
    // Error and unlock together on the first sample.
    start_at[35] = 1;  code_at[35] = 16'h9876;  err_at[40] = 1; unl_at[40] = 1;
    // Timeout; an unlock during sending must be ignored.
    start_at[65] = 1;  code_at[65] = 16'h0A5C;  unl_at[67] = 1;
    // Lockdown beats error and unlock.
    start_at[95] = 1;  code_at[95] = 16'h1111;
    warn_at[102] = 1;  unl_at[102] = 1; err_at[102] = 1;
    // Unlock on the final sample; start while busy is ignored.
    start_at[125] = 1; code_at[125] = 16'h2468; unl_at[137] = 1; start_at[133] = 1;
    // Reset mid-send, then an immediate new attempt.
    start_at[155] = 1; code_at[155] = 16'h7531; rst_at[157] = 1;
    start_at[158] = 1; code_at[158] = 16'hBEEF; unl_at[163] = 1;
    // Start held: back-to-back attempts with changing codes.
    for (int e = 190; e <= 260; e++) begin
      start_at[e] = 1;
      code_at[e]  = 16'(e * 32'h1357);
    end
    unl_at[228] = 1;
  endtask

  task automatic run_model();
    int  ep;
    int  cs, cl, cc;
    ep = 0;
    for (int e = 0; e < N; e++) begin
      e_digit[e] = 4'hF; e_valid[e] = 0; e_busy[e] = 0; e_done[e] = 0;
      ev_kind[e] = 0; ev_s[e] = 0; ev_l[e] = 0;
    end
    for (int e = 0; e < N; e++) begin
      if (rst_at[e]) begin
        ev_kind[e] = 1;
        ep = e + 1;
      end else if (e >= ep && start_at[e]) begin
        int t, s, dne, fin, r, last;
        bit res, lk;
        t = e; s = t + D + T; res = 0; lk = 0; r = -1;
        for (int j = 0; j < T; j++) begin
          int x;
          x = t + D + 1 + j;
          if (warn_at[x])      begin s = x; lk = 1; break; end
          else if (err_at[x])  begin s = x; break; end
          else if (unl_at[x])  begin s = x; res = 1; break; end
        end
        dne = s + 1 + ((ADM && lk) ? 4 : 0);
        fin = dne + 1;
        for (int x = t + 1; x <= fin && x < N; x++)
          if (rst_at[x]) begin r = x; break; end
        last = (r >= 0) ? r - 1 : fin;
        for (int x = t; x <= last && x < N; x++) begin
          if (x < fin) e_busy[x] = 1;
          if (x - t < D) begin
            e_valid[x] = 1;
            e_digit[x] = code_at[t][4*(x-t) +: 4];
          end
          if (ADM && lk && x >= s && x <= s + 3) begin
            e_valid[x] = 1;
            e_digit[x] = admin_digit(x - s);
          end
          if (x == dne) e_done[x] = 1;
        end
        ev_kind[t] = 2;
        if (r < 0 || r > dne) begin
          ev_kind[dne] = 3; ev_s[dne] = res; ev_l[dne] = lk;
        end
        ep = (r >= 0) ? r + 1 : fin + 1;
      end
    end
    cs = 0; cl = 0; cc = 0;
    for (int e = 0; e < N; e++) begin
      case (ev_kind[e])
        1: begin cs = 0; cl = 0; cc = 1; end
        2: cc = 0;
        3: begin cs = int'(ev_s[e]); cl = int'(ev_l[e]); cc = 1; end
        default: ;
      endcase
      e_chk[e] = (cc != 0); e_succ[e] = (cs != 0); e_lock[e] = (cl != 0);
    end
  endtask

  task automatic apply(input int x);
    RST = rst_at[x]; start = start_at[x]; code = code_at[x];
    unlockLight = unl_at[x]; errorLight = err_at[x]; warningLight = warn_at[x];
  endtask

  initial begin
    int nd;
    build_stimulus();
    run_model();
    apply(0);
    for (int e = 0; e < N; e++) begin
      @(posedge CLK);
      #1;
      o_digit[e] = digit; o_valid[e] = digitValid; o_busy[e] = busy;
      o_done[e] = done;   o_succ[e] = success;     o_lock[e] = lockedOut;
      check($sformatf("digitValid@%0d", e), 32'(digitValid), 32'(e_valid[e]));
      check($sformatf("digit@%0d", e),      32'(digit),      32'(e_digit[e]));
      check($sformatf("busy@%0d", e),       32'(busy),       32'(e_busy[e]));
      check($sformatf("done@%0d", e),       32'(done),       32'(e_done[e]));
      if (e_chk[e]) begin
        check($sformatf("success@%0d", e),   32'(success),   32'(e_succ[e]));
        check($sformatf("lockedOut@%0d", e), 32'(lockedOut), 32'(e_lock[e]));
      end
      if (e + 1 < N) apply(e + 1);
    end

    // Hand-computed pins.
    check("pin_digits_4321", 32'({o_digit[5], o_digit[6], o_digit[7], o_digit[8]}), 32'h1234);
    check("pin_unlock_done", 32'({o_done[12], o_succ[12], o_lock[12]}), 32'b110);
    check("pin_error_prio",  32'({o_done[41], o_succ[41]}), 32'b10);
    check("pin_timeout",     32'({o_done[77], o_done[78], o_succ[78]}), 32'b010);
`ifdef PASSWORD_SENDER_ADMIN_EN
    check("pin_admin_digits", 32'({o_digit[102], o_digit[103], o_digit[104], o_digit[105]}), 32'h0129);
    check("pin_admin_valid",  32'({o_valid[102], o_valid[103], o_valid[104], o_valid[105]}), 32'hF);
    check("pin_admin_done",   32'({o_done[107], o_succ[107], o_lock[107]}), 32'b101);
`else
    check("pin_lock_novalid", 32'({o_valid[102], o_valid[103], o_valid[104], o_valid[105]}), 32'h0);
    check("pin_lock_done",    32'({o_done[103], o_succ[103], o_lock[103]}), 32'b101);
`endif
    check("pin_last_sample", 32'({o_done[138], o_succ[138]}), 32'b11);
    check("pin_reset_abort", 32'({o_valid[157], o_busy[157], o_digit[157]}), 32'h00F);
    nd = 0;
    for (int e = 155; e < 164; e++) if (o_done[e] === 1'b1) nd++;
    check("pin_no_done_abort", 32'(nd), 32'd0);
    check("pin_restart",     32'({o_done[164], o_succ[164]}), 32'b11);
    check("pin_back2back",   32'({o_done[203], o_valid[204], o_valid[205]}), 32'b101);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/password_sender.md
# password_sender

Serial transmitter for the password lock's digit bus. On a start request it latches a multi-digit code, drives it onto the lock's `digit` input one digit per clock, then watches the lock's result lights and reports unlock success or failure. It sits in front of the lock in the test/automation path and replaces a human keypad operator. When its configuration macro is defined, it can also play the admin recovery sequence after the lock enters lockdown.

## Interface
Parameters:
- `DIGITS`, default 4: number of code digits sent per attempt; must be ≥1.
- `IDLE_DIGIT`, default 4'hF: value driven on `digit` whenever no digit is being sent.
- `RESP_TIMEOUT`, default 8: maximum cycles spent waiting for a result light after the last digit; must be ≥1.

Ports:
- `CLK` in 1: the single clock.
- `RST` in 1: reset, synchronous and active-high. This is the only reset.
- `start` in 1: request to send an attempt. Sampled only in S_IDLE.
- `code` in 4*DIGITS: code to send. Digit k occupies `code[4k+3:4k]`; digit 0 is sent first.
- `digit` out 4: digit driven to the lock.
- `digitValid` out 1: high on every cycle in which `digit` carries a code or admin digit.
- `busy` out 1: high in every state except S_IDLE.
- `done` out 1: single-cycle pulse when an attempt finishes.
- `success` out 1: result of the last attempt. Valid from the `done` cycle and held until the next accepted `start`.
- `lockedOut` out 1: result qualifier. Held with `success`; high if `warningLight` was seen during the attempt.
- `unlockLight` in 1: lock result input.
- `errorLight` in 1: lock result input.
- `warningLight` in 1: lock lockdown indicator.

## Operation
States: S_IDLE, S_SEND, S_WAIT, S_ADMIN, S_DONE.
- **S_IDLE**
  - `start`=1: latch `code` into the shift register, clear `success` and `lockedOut`, clear the digit index, go to S_SEND.
- **S_SEND**
  - Drive `digit` = current digit with `digitValid`=1, then advance the index.
  - After digit DIGITS-1: load the wait counter with RESP_TIMEOUT and go to S_WAIT.
- **S_WAIT**: sample the result inputs every cycle, in this priority order:
  - `warningLight`: set `lockedOut`, `success`=0, go to S_ADMIN (macro defined) or S_DONE.
  - `errorLight`: `success`=0, go to S_DONE. Error beats unlock when both are high in the same cycle.
  - `unlockLight`: `success`=1, go to S_DONE.
  - Counter reaches 0: timeout, `success`=0, go to S_DONE.
- **S_ADMIN**
  - Send the admin sequence 0,1,2,9, one digit per cycle, with `digitValid`=1.
  - Then go to S_DONE. `success` stays 0.
- **S_DONE**: `done`=1 for one cycle, then go to S_IDLE.
- `start` outside S_IDLE is ignored and not queued.

Reset:
- Outputs after reset: `digit`=IDLE_DIGIT, `digitValid`=0, `busy`=0, `done`=0, `success`=0, `lockedOut`=0.
- State = S_IDLE and all counters = 0.
- Reset in the middle of an attempt aborts it on the next edge. No `done` pulse is produced for the aborted attempt.

Width rule: the digit index and wait counter are sized with `$clog2` of their maximum value plus 1, and never wrap.

## Timing
- `start` sampled high at edge t: digit 0 is valid in the cycle after t, and digit k in cycle t+1+k.
- First result sample: the cycle after the last digit.
- `done` arrives 2 cycles after the deciding result sample. The extra cycle comes from S_DONE.
- Without admin: worst case from `start` to `done` is DIGITS+RESP_TIMEOUT+2 cycles.
- With admin: the admin sequence adds 4 cycles.
- Back-to-back: `start` may be high on the cycle after `done` and is accepted there.
- All outputs are registered. There are no combinational paths from input to output.

## Configuration
- Macro: `PASSWORD_SENDER_ADMIN_EN`.
- Defined: S_ADMIN exists, and lockdown triggers the 0,1,2,9 recovery sequence.
- Undefined:
  - S_ADMIN is not compiled in.
  - `warningLight` is treated as an error: `lockedOut`=1, `success`=0, go straight to S_DONE.
  - No admin digits are ever driven.

## Structure
- Package `password_sender_pkg` holds:
  - the state enum (3-bit);
  - the ADMIN_CODE constant (0,1,2,9) and its length of 4;
  - the default IDLE_DIGIT.
- Sub-module `digit_serializer`:
  - loads a vector of DIGITS×4 bits;
  - shifts out one digit per enabled cycle;
  - flags the last digit.
- The main FSM reuses `digit_serializer` for the admin sequence by loading ADMIN_CODE.

## Test plan
- Success: code 0x4321, `unlockLight` pulsed 2 cycles after the last digit → `digit` sequence 1,2,3,4 → `done`, `success`=1, `lockedOut`=0.
- Error: `errorLight` and `unlockLight` both high on the first result sample → `success`=0.
- Timeout: no result light → `done` at start+1+4+8+1, `success`=0.
- Lockdown with the macro defined: `warningLight` high → `digit` 0,1,2,9 with `digitValid`, then `done`, `lockedOut`=1, `success`=0. With the macro undefined: no admin digits and `done` 2 cycles after the sample.
- Reset asserted mid S_SEND → `digit`=IDLE_DIGIT, `busy`=0 next cycle, no `done`. A new `start` immediately afterwards runs normally.
- `start` held high continuously → attempts run back-to-back, and each `done` is followed by a new digit 0 two cycles later.
